// File: rtl/register_file_mp_pkg.sv
// Shared constants for the multi-port register file: port-count limits and
// the default word width (taken from `WORD_LENGTH, 32 when not supplied).
`ifndef WORD_LENGTH
`define WORD_LENGTH 32
`endif

package register_file_mp_pkg;

  localparam int unsigned WORD_LENGTH = `WORD_LENGTH;
  localparam int unsigned MAX_READ    = 4;
  localparam int unsigned MAX_WRITE   = 3;

  typedef logic [WORD_LENGTH-1:0] word_t;

endpackage

// File: rtl/register_file_mp_scoreboard.sv
// Pending-result scoreboard: one bit per register, set by reserve, cleared by
// any enabled write to that register (reserve wins on the same address), and a
// registered population count of the pending bits.
module regfile_scoreboard
  import register_file_mp_pkg::*;
#(
  parameter int unsigned SIZE      = 16,
  parameter int unsigned NUM_WRITE = 2,
  parameter int unsigned AW        = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_WRITE-1:0]    i_write_en,
  input  logic [NUM_WRITE*AW-1:0] i_write_addr,
  input  logic                    i_reserve_en,
  input  logic [AW-1:0]           i_reserve_addr,
  output logic [SIZE-1:0]         o_pending,
  output logic [AW:0]             o_pending_count
);

  logic [SIZE-1:0] r_pending;
  logic [SIZE-1:0] w_pending_nxt;
  logic [AW:0]     r_count;
  logic [AW:0]     w_count_nxt;

  // Next pending vector (clears first, then reserve overrides) and its popcount.
  always_comb begin
    w_pending_nxt = r_pending;
    for (int unsigned i = 0; i < NUM_WRITE; i++) begin
      if (i_write_en[i]) begin
        w_pending_nxt[i_write_addr[i*AW +: AW]] = 1'b0;
      end
    end
    if (i_reserve_en) begin
      w_pending_nxt[i_reserve_addr] = 1'b1;
    end
    w_count_nxt = '0;
    for (int unsigned k = 0; k < SIZE; k++) begin
      w_count_nxt = w_count_nxt + {{AW{1'b0}}, w_pending_nxt[k]};
    end
  end

  // Pending bits and count update together so the count never disagrees.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending <= '0;
      r_count   <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      r_count   <= w_count_nxt;
    end
  end

  assign o_pending       = r_pending;
  assign o_pending_count = r_count;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with pending-result scoreboard.
// Define REGISTER_FILE_BYPASS_EN to forward same-cycle write data to reads.
module register_file_mp
  import register_file_mp_pkg::*;
#(
  parameter  int unsigned SIZE      = 16,
  parameter  int unsigned WIDTH     = WORD_LENGTH,
  parameter  int unsigned NUM_READ  = 3,
  parameter  int unsigned NUM_WRITE = 2,
  localparam int unsigned AW        = $clog2(SIZE)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_READ*AW-1:0]     readAddr,
  output logic [NUM_READ*WIDTH-1:0]  readData,
  output logic [NUM_READ-1:0]        readBusy,
  input  logic [NUM_WRITE-1:0]       writeEnable,
  input  logic [NUM_WRITE*AW-1:0]    writeAddr,
  input  logic [NUM_WRITE*WIDTH-1:0] writeData,
  input  logic                       reserveEnable,
  input  logic [AW-1:0]              reserveAddr,
  output logic [AW:0]                pendingCount
);

  logic [WIDTH-1:0] r_mem [SIZE];
  logic [SIZE-1:0]  w_pending;

  regfile_scoreboard #(
    .SIZE      (SIZE),
    .NUM_WRITE (NUM_WRITE),
    .AW        (AW)
  ) u_scoreboard (
    .clk             (clk),
    .rst             (rst),
    .i_write_en      (writeEnable),
    .i_write_addr    (writeAddr),
    .i_reserve_en    (reserveEnable),
    .i_reserve_addr  (reserveAddr),
    .o_pending       (w_pending),
    .o_pending_count (pendingCount)
  );

  // Storage write; ports applied highest-first so the lowest index wins collisions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < SIZE; k++) begin
        r_mem[k] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_WRITE; i++) begin
        if (writeEnable[NUM_WRITE-1-i]) begin
          r_mem[writeAddr[(NUM_WRITE-1-i)*AW +: AW]] <= writeData[(NUM_WRITE-1-i)*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Combinational read muxing, optionally forwarding same-cycle write data.
  always_comb begin
    readData = '0;
    readBusy = '0;
    for (int unsigned p = 0; p < NUM_READ; p++) begin
      readData[p*WIDTH +: WIDTH] = r_mem[readAddr[p*AW +: AW]];
      readBusy[p]                = w_pending[readAddr[p*AW +: AW]];
`ifdef REGISTER_FILE_BYPASS_EN
      // Highest-first scan: the last match (lowest index) is the forwarded one.
      for (int unsigned i = 0; i < NUM_WRITE; i++) begin
        if (writeEnable[NUM_WRITE-1-i] &&
            (writeAddr[(NUM_WRITE-1-i)*AW +: AW] == readAddr[p*AW +: AW])) begin
          readData[p*WIDTH +: WIDTH] = writeData[(NUM_WRITE-1-i)*WIDTH +: WIDTH];
          readBusy[p] = reserveEnable && (reserveAddr == readAddr[p*AW +: AW]);
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Scoreboard bench for register_file_mp: stimulus queues expected outputs,
// a monitor on the falling edge pops and compares them.
module tb_register_file_mp;

`ifdef REGISTER_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] readAddr;
  logic [95:0] readData;
  logic [2:0]  readBusy;
  logic [1:0]  writeEnable;
  logic [7:0]  writeAddr;
  logic [63:0] writeData;
  logic        reserveEnable;
  logic [3:0]  reserveAddr;
  logic [4:0]  pendingCount;

  register_file_mp #(
    .SIZE      (16),
    .WIDTH     (32),
    .NUM_READ  (3),
    .NUM_WRITE (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .readAddr      (readAddr),
    .readData      (readData),
    .readBusy      (readBusy),
    .writeEnable   (writeEnable),
    .writeAddr     (writeAddr),
    .writeData     (writeData),
    .reserveEnable (reserveEnable),
    .reserveAddr   (reserveAddr),
    .pendingCount  (pendingCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;   // 0 data, 1 busy, 2 count
    int          port;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        m_e;
  logic [31:0] m_act;

  task automatic push(input int kind, input int port, input logic [31:0] v, input string nm);
    exp_t e;
    e.kind = kind;
    e.port = port;
    e.exp  = v;
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic exp_rd(input int port, input logic [31:0] d, input logic b, input string nm);
    push(0, port, d, {nm, "_data"});
    push(1, port, {31'b0, b}, {nm, "_busy"});
  endtask

  task automatic exp_cnt(input int n, input string nm);
    push(2, 0, n, {nm, "_cnt"});
  endtask

  task automatic set_rd(input int port, input logic [3:0] a);
    readAddr[port*4 +: 4] = a;
  endtask

  task automatic idle();
    writeEnable   = '0;
    reserveEnable = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every queued expectation against the settled outputs.
  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        m_e = q.pop_front();
        case (m_e.kind)
          0:       m_act = readData[m_e.port*32 +: 32];
          1:       m_act = {31'b0, readBusy[m_e.port]};
          default: m_act = {27'b0, pendingCount};
        endcase
        n_checks++;
        if (m_act !== m_e.exp) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", m_e.name, m_act, m_e.exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] pm;
    rst           = 1'b0;
    readAddr      = '0;
    writeEnable   = '0;
    writeAddr     = '0;
    writeData     = '0;
    reserveEnable = 1'b0;
    reserveAddr   = '0;
    exp_cnt(0, "in_reset");
    exp_rd(0, 32'h0, 1'b0, "in_reset");
    step();
    rst = 1'b1;

    // All registers read zero / not busy after reset.
    for (int r = 0; r < 16; r++) begin
      set_rd(0, 4'(r));
      set_rd(1, 4'((r + 1) % 16));
      set_rd(2, 4'((r + 2) % 16));
      exp_rd(0, 32'h0, 1'b0, "rst_rd0");
      exp_rd(1, 32'h0, 1'b0, "rst_rd1");
      exp_rd(2, 32'h0, 1'b0, "rst_rd2");
      exp_cnt(0, "rst");
      step();
    end

    // Write collision on reg 5: port 0 wins.
    writeEnable = 2'b11;
    writeAddr   = {4'd5, 4'd5};
    writeData   = {32'h5555FFFF, 32'hAAAA0000};
    set_rd(0, 4'd5);
    exp_rd(0, BYP ? 32'hAAAA0000 : 32'h0, 1'b0, "coll_same");
    step();
    idle();
    exp_rd(0, 32'hAAAA0000, 1'b0, "coll_next");
    step();

    // Reserve reg 3, then write it from port 1.
    reserveEnable = 1'b1;
    reserveAddr   = 4'd3;
    set_rd(1, 4'd3);
    exp_rd(1, 32'h0, 1'b0, "res3_a");
    exp_cnt(0, "res3_a");
    step();
    idle();
    exp_rd(1, 32'h0, 1'b1, "res3_b");
    exp_cnt(1, "res3_b");
    step();
    writeEnable = 2'b10;
    writeAddr   = {4'd3, 4'd0};
    writeData   = {32'h12345678, 32'h0};
    exp_rd(1, BYP ? 32'h12345678 : 32'h0, BYP ? 1'b0 : 1'b1, "res3_c");
    exp_cnt(1, "res3_c");
    step();
    idle();
    exp_rd(1, 32'h12345678, 1'b0, "res3_d");
    exp_cnt(0, "res3_d");
    step();

    // Reserve and write reg 7 in the same cycle: reserve wins.
    reserveEnable = 1'b1;
    reserveAddr   = 4'd7;
    writeEnable   = 2'b01;
    writeAddr     = {4'd0, 4'd7};
    writeData     = {32'h0, 32'hDEADBEEF};
    set_rd(2, 4'd7);
    exp_rd(2, BYP ? 32'hDEADBEEF : 32'h0, BYP ? 1'b1 : 1'b0, "rw7_a");
    exp_cnt(0, "rw7_a");
    step();
    idle();
    exp_rd(2, 32'hDEADBEEF, 1'b1, "rw7_b");
    exp_cnt(1, "rw7_b");
    step();

    // Bypass vs. registered visibility on reg 2.
    writeEnable = 2'b01;
    writeAddr   = {4'd0, 4'd2};
    writeData   = {32'h0, 32'h0BADC0DE};
    set_rd(0, 4'd2);
    exp_rd(0, BYP ? 32'h0BADC0DE : 32'h0, 1'b0, "byp_a");
    step();
    writeData = {32'h0, 32'hCAFEF00D};
    exp_rd(0, BYP ? 32'hCAFEF00D : 32'h0BADC0DE, 1'b0, "byp_b");
    exp_cnt(1, "byp_b");
    step();
    idle();
    exp_rd(0, 32'hCAFEF00D, 1'b0, "byp_c");
    step();

    // Reserve every register; count saturates at 16 without wrapping.
    pm = 16'h0080;
    for (int k = 0; k < 16; k++) begin
      reserveEnable = 1'b1;
      reserveAddr   = 4'(k);
      exp_cnt($countones(pm), "fill");
      pm[k] = 1'b1;
      step();
    end
    reserveAddr = 4'd0;
    exp_cnt(16, "full_a");
    step();

    // Asynchronous reset mid-sequence with reserve and write still active.
    reserveAddr = 4'd5;
    writeEnable = 2'b01;
    writeAddr   = {4'd0, 4'd9};
    writeData   = {32'h0, 32'hFFFFFFFF};
    set_rd(0, 4'd2);
    set_rd(1, 4'd5);
    set_rd(2, 4'd7);
    #2;
    rst = 1'b0;
    exp_cnt(0, "async_rst");
    exp_rd(0, 32'h0, 1'b0, "async_rst_r2");
    exp_rd(2, 32'h0, 1'b0, "async_rst_r7");
    step();
    exp_cnt(0, "hold_rst");
    step();
    rst         = 1'b1;
    writeEnable = '0;
    exp_cnt(0, "post_rst_a");
    exp_rd(1, 32'h0, 1'b0, "post_rst_a");
    step();
    idle();
    set_rd(2, 4'd9);
    exp_cnt(1, "post_rst_b");
    exp_rd(1, 32'h0, 1'b1, "post_rst_b5");
    exp_rd(2, 32'h0, 1'b0, "post_rst_b9");
    step();

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
